// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM states (BOOT, RUN, HALT)
//   INSTR_BYTES      : byte stride between sequential instructions
//   DEFAULT_HALT_ENC : default instruction encoding that stops fetch
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_HALT_ENC = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bus between the fetch stage and its neighbours.
// It carries the hazard/branch controls coming in, the instruction-memory
// address/data pair, and the IF/ID-facing fields going out.
//   master : fetch stage side (drives PC, instruction, valid, status, counter)
//   slave  : environment side (hazard unit, branch unit, imem, IF/ID register)
interface fetch_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
);

  logic               stall_i;
  logic               br_taken_i;
  logic [ADDR_W-1:0]  br_target_i;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic [ADDR_W-1:0]  pc_o;
  logic [ADDR_W-1:0]  pc_plus4_o;
  logic [INSTR_W-1:0] instr_o;
  logic               valid_o;
  logic               halted_o;
  logic [CNT_W-1:0]   fetch_cnt_o;

  modport master (
    input  stall_i, br_taken_i, br_target_i, imem_data_i,
    output imem_addr_o, pc_o, pc_plus4_o, instr_o, valid_o, halted_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, br_taken_i, br_target_i, imem_data_i,
    input  imem_addr_o, pc_o, pc_plus4_o, instr_o, valid_o, halted_o, fetch_cnt_o
  );

endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch FSM and next-PC select.
//   state | meaning
//   BOOT  | first cycle after reset, nothing valid yet, stall ignored
//   RUN   | fetching sequentially, honouring stall and redirects
//   HALT  | halt instruction retired, PC frozen until a redirect
// Ports:
//   clk, reset        : clock, async active-low reset
//   stall, br_taken   : hazard hold / resolved taken branch
//   br_target         : redirect target (low two bits forced to zero)
//   pc, instr         : current PC register and combinational imem data
//   pc_nxt            : value the PC register loads at the next edge
//   valid, halted     : IF/ID valid bit and HALT status
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 64,
  parameter int                 INSTR_W  = 32,
  parameter logic [INSTR_W-1:0] HALT_ENC = INSTR_W'(DEFAULT_HALT_ENC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_nxt,
  output logic               valid,
  output logic               halted
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] target_al;
  logic [ADDR_W-1:0] pc_seq;

  // Misaligned targets are a caller error; dropping the low bits keeps the
  // PC word aligned no matter what arrives.
  assign target_al = br_target & ~ADDR_W'(INSTR_BYTES - 1);
  assign pc_seq    = pc + ADDR_W'(INSTR_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid     = 1'b0;
    halted    = 1'b0;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
        if (br_taken) pc_nxt = target_al;
      end
      RUN: begin
        // A redirect squashes the wrong-path instruction in the same cycle.
        valid = ~br_taken;
        if (br_taken) begin
          pc_nxt = target_al;
        end else if (!stall) begin
          // The halt instruction itself goes downstream; the PC then parks on it.
          if (instr == HALT_ENC) state_nxt = HALT;
          else                   pc_nxt    = pc_seq;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (br_taken) begin
          pc_nxt    = target_al;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage top. Holds the PC register and the
// retired-fetch counter; FSM and next-PC select live in fetch_ctrl.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fetch_if master (stall/branch/imem data in; imem address,
//           PC, PC+4, instruction, valid, halted and fetch count out)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 64,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INSTR_W-1:0] HALT_ENC = INSTR_W'(DEFAULT_HALT_ENC),
  parameter int                 CNT_W    = 32
) (
  input logic      clk,
  input logic      reset,
  fetch_if.master  bus
);

  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              valid, halted;

  fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .HALT_ENC (HALT_ENC)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .stall     (bus.stall_i),
    .br_taken  (bus.br_taken_i),
    .br_target (bus.br_target_i),
    .pc        (pc),
    .instr     (bus.imem_data_i),
    .pc_nxt    (pc_nxt),
    .valid     (valid),
    .halted    (halted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end

  // Counts instructions IF/ID actually captures: valid and not held by a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    fetch_cnt <= '0;
    else if (valid && !bus.stall_i) fetch_cnt <= fetch_cnt + CNT_W'(1);
  end

  assign bus.imem_addr_o = pc;
  assign bus.pc_o        = pc;
  assign bus.pc_plus4_o  = pc + ADDR_W'(INSTR_BYTES);
  assign bus.instr_o     = bus.imem_data_i;
  assign bus.valid_o     = valid;
  assign bus.halted_o    = halted;
  assign bus.fetch_cnt_o = fetch_cnt;

endmodule
